// File: rtl/sync_xfer_pkg.sv
// Shared types for the sync transfer scheduler.
// State encoding used by the scheduler FSM.
package sync_xfer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

endpackage

// File: rtl/sync_xfer_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
// First set request at or above ptr wins, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               any_req
);

  logic             found;
  logic [PTR_W-1:0] j;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[j]) begin
        found      = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = j;
      end
      j = (j == PTR_W'(NUM_REQ - 1)) ? '0 : j + 1'b1;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sync_xfer_scheduler.sv
// Source-domain scheduler sharing one data synchroniser crossing.
// Define ACK_WAIT_EN to add the xfer_ack handshake state.
module sync_xfer_scheduler
  import sync_xfer_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  input  logic [CNT_WIDTH-1:0]         hold_cfg,
  input  logic [CNT_WIDTH-1:0]         gap_cfg,
`ifdef ACK_WAIT_EN
  input  logic                         xfer_ack,
`endif
  output logic [NUM_REQ-1:0]           grant,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic                         busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [PTR_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   win_oh;
  logic [PTR_W-1:0]     win_idx;
  logic                 any_req;
  logic [BUS_WIDTH-1:0] word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) word = word | req_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            unsync_bus <= word;
            bus_enable <= 1'b1;
            grant      <= win_oh;
            cnt        <= hold_cfg;
            state      <= HOLD;
            ptr        <= (win_idx == PTR_W'(NUM_REQ - 1)) ?
                          '0 : win_idx + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            bus_enable <= 1'b0;
`ifdef ACK_WAIT_EN
            state      <= WAIT_ACK;
`else
            cnt        <= gap_cfg;
            state      <= GAP;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef ACK_WAIT_EN
        WAIT_ACK: begin
          if (xfer_ack) begin
            cnt   <= gap_cfg;
            state <= GAP;
          end
        end
`endif
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_xfer_scheduler.sv
// Self-checking bench for sync_xfer_scheduler.
// Scoreboard of expected transfers checked by a bus monitor.
module tb_sync_xfer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  hold_cfg;
  logic [3:0]  gap_cfg;
`ifdef ACK_WAIT_EN
  logic        xfer_ack;
`endif
  logic [3:0]  grant;
  logic [7:0]  unsync_bus;
  logic        bus_enable;
  logic        busy;

  typedef struct {
    logic [3:0] g;
    logic [7:0] d;
    int         hi;
    int         min_low;
    bit         exact;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  sync_xfer_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .hold_cfg   (hold_cfg),
    .gap_cfg    (gap_cfg),
`ifdef ACK_WAIT_EN
    .xfer_ack   (xfer_ack),
`endif
    .grant      (grant),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Bus monitor: pops on each grant, measures high and low windows.
  bit         m_active = 0;
  bit         m_prev   = 0;
  int         m_hi     = 0;
  int         m_hi_exp = 0;
  int         m_low    = 0;
  logic [7:0] m_data   = '0;
  exp_t       e;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_active = 0;
      m_prev   = 0;
    end else if (grant != 4'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_grant: got %b, required none", grant);
      end else begin
        e = sb.pop_front();
        if (grant !== e.g) begin
          n_fails++;
          $display("FAIL grant: got %b, required %b", grant, e.g);
        end
        n_checks++;
        if (unsync_bus !== e.d) begin
          n_fails++;
          $display("FAIL capture: got %h, required %h", unsync_bus, e.d);
        end
        n_checks++;
        if (bus_enable !== 1'b1) begin
          n_fails++;
          $display("FAIL en_rise: got %b, required 1", bus_enable);
        end
        if (m_prev) begin
          n_checks++;
          if (e.exact ? (m_low != e.min_low) : (m_low < e.min_low)) begin
            n_fails++;
            $display("FAIL low_gap: got %0d, required %s%0d",
                     m_low, e.exact ? "" : ">=", e.min_low);
          end
        end
        m_hi_exp = e.hi;
        m_data   = e.d;
        m_hi     = 1;
        m_active = 1;
      end
    end else if (m_active) begin
      if (bus_enable) begin
        m_hi++;
        n_checks++;
        if (unsync_bus !== m_data) begin
          n_fails++;
          $display("FAIL bus_stable: got %h, required %h", unsync_bus, m_data);
        end
      end else begin
        if (m_hi_exp >= 0) begin
          n_checks++;
          if (m_hi != m_hi_exp) begin
            n_fails++;
            $display("FAIL high_window: got %0d, required %0d", m_hi, m_hi_exp);
          end
        end
        m_active = 0;
        m_prev   = 1;
        m_low    = 1;
      end
    end else if (!bus_enable) begin
      m_low++;
    end
  end

  // Requester model; sticky keeps req until the scoreboard drains.
  task automatic run(input logic [3:0] r, input bit sticky,
                     input int budget, output bit ok);
    req = r;
    ok  = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sticky) begin
        if (sb.size() == 0) req = '0;
      end else begin
        req = req & ~grant;
      end
      if (sb.size() == 0 && !busy && !m_active) begin
        ok = 1;
        break;
      end
    end
    req = '0;
  endtask

  task automatic test_reset;
    bit ok;
    rst_n    = 1'b0;
    req      = 4'b1111;
    req_data = 32'hDDCCBB5C;
    hold_cfg = 4'd3;
    gap_cfg  = 4'd2;
`ifdef ACK_WAIT_EN
    xfer_ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (grant !== 4'b0) begin
      n_fails++;
      $display("FAIL rst_grant: got %b, required 0000", grant);
    end
    n_checks++;
    if (unsync_bus !== 8'h00) begin
      n_fails++;
      $display("FAIL rst_bus: got %h, required 00", unsync_bus);
    end
    n_checks++;
    if (bus_enable !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_en: got %b, required 0", bus_enable);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_busy: got %b, required 0", busy);
    end
    sb.push_back('{4'b0001, 8'h5C, 4, 0, 0});
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fails++;
      $display("FAIL first_grant: got %b, required 0001", grant);
    end
    req = '0;
    run(4'b0000, 0, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL reset_drain: got timeout, required idle");
    end
  endtask

  task automatic test_basic;
    bit ok;
    hold_cfg = 4'd3;
    gap_cfg  = 4'd2;
    req_data = 32'h33A52211;
    sb.push_back('{4'b0100, 8'hA5, 4, 0, 0});
    sb.push_back('{4'b0100, 8'hA5, 4, 4, 1});
    run(4'b0100, 1, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL basic_drain: got timeout, required idle");
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    // Start from pointer 0 so the rotation order is known.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    hold_cfg = 4'd0;
    gap_cfg  = 4'd0;
    req_data = 32'h13121110;
    sb.push_back('{4'b0001, 8'h10, 1, 2, 1});
    sb.push_back('{4'b0010, 8'h11, 1, 2, 1});
    sb.push_back('{4'b0100, 8'h12, 1, 2, 1});
    sb.push_back('{4'b1000, 8'h13, 1, 2, 1});
    sb.push_back('{4'b0001, 8'h10, 1, 2, 1});
    run(4'b1111, 1, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL b2b_drain: got timeout, required idle");
    end
  endtask

  task automatic test_cfg_change;
    bit ok;
    bit seen;
    hold_cfg = 4'd3;
    gap_cfg  = 4'd1;
    req_data = 32'h0000007E;
    sb.push_back('{4'b0001, 8'h7E, 4, 0, 0});
    sb.push_back('{4'b0001, 8'h7E, 8, 3, 1});
    seen = 0;
    fork
      run(4'b0001, 1, 300, ok);
      begin
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (grant != 4'b0) begin
            seen = 1;
            break;
          end
        end
        hold_cfg = 4'd7;
      end
    join
    n_checks++;
    if (!ok || !seen) begin
      n_fails++;
      $display("FAIL cfg_drain: got ok=%0d seen=%0d, required 1 1", ok, seen);
    end
  endtask

  task automatic test_reset_mid_hold;
    bit ok;
    bit seen;
    hold_cfg = 4'd7;
    gap_cfg  = 4'd1;
    req_data = 32'h9F00E100;
    sb.push_back('{4'b0010, 8'hE1, -1, 0, 0});
    seen = 0;
    @(negedge clk);
    req = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (grant != 4'b0) begin
        seen = 1;
        break;
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (!seen || bus_enable !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset: got seen=%0d en=%b busy=%b, required 1 0 0",
               seen, bus_enable, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      n_fails++;
      $display("FAIL post_reset_idle: got busy=%b grant=%b, required 0 0000",
               busy, grant);
    end
    sb.push_back('{4'b0010, 8'hE1, 8, 0, 0});
    sb.push_back('{4'b1000, 8'h9F, 8, 0, 0});
    run(4'b1010, 0, 300, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL mid_drain: got timeout, required idle");
    end
  endtask

`ifdef ACK_WAIT_EN
  task automatic test_ack_wait;
    bit ok;
    bit bad;
    int n;
    hold_cfg = 4'd1;
    gap_cfg  = 4'd1;
    req_data = 32'h0000003C;
    sb.push_back('{4'b0001, 8'h3C, 2, 0, 0});
    bad = 0;
    n   = 0;
    fork
      run(4'b0001, 0, 300, ok);
      begin
        for (int c = 0; c < 50 && !bus_enable; c++) @(negedge clk);
        for (int c = 0; c < 50 && bus_enable; c++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
          if (busy !== 1'b1 || grant !== 4'b0) bad = 1;
          @(negedge clk);
        end
        xfer_ack = 1'b1;
        @(negedge clk);
        xfer_ack = 1'b0;
        while (busy && n < 50) begin
          n++;
          @(negedge clk);
        end
      end
    join
    n_checks++;
    if (bad) begin
      n_fails++;
      $display("FAIL ack_hold: got early release, required busy until ack");
    end
    n_checks++;
    if (n != 2) begin
      n_fails++;
      $display("FAIL ack_gap: got %0d busy cycles, required 2", n);
    end
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL ack_drain: got timeout, required idle");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_hold();
`ifdef ACK_WAIT_EN
    test_ack_wait();
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL sb_leftover: got %0d, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
